// File: rtl/rtc_calendar.sv
// BCD real-time clock/calendar on the slot-I/O register bus: prescaled 1 Hz
// time base, leap-year calendar, coherent read snapshot and a time-of-day alarm.
module rtc_calendar #(
  parameter int          CLK_HZ  = 25_000_000,
  parameter logic [7:0]  CENTURY = 8'h20
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cs_i,
  input  logic       we_i,
  input  logic [3:0] address_i,
  input  logic [7:0] db_i,
  output logic [7:0] db_o,
  output logic       tick_1hz_o,
  output logic       alarm_irq_o,
  output logic [5:0] hours_o,
  output logic [6:0] min_o,
  output logic [6:0] sec_o
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic          alarmEval_q, alarmEval_d;
  logic [6:0]    sec_q, sec_d;
  logic [6:0]    min_q, min_d;
  logic [5:0]    hour_q, hour_d;
  logic [2:0]    dow_q, dow_d;
  logic [5:0]    date_q, date_d;
  logic [4:0]    month_q, month_d;
  logic [7:0]    year_q, year_d;
  logic [7:0]    almSec_q, almSec_d;
  logic [7:0]    almMin_q, almMin_d;
  logic [7:0]    almHour_q, almHour_d;
  logic          halt_q, halt_d;
  logic          ie_q, ie_d;
  logic          flag_q, flag_d;
  logic [34:0]   shadow_q, shadow_d;

  // Returns {carry, next}; anything at or beyond the limit wraps to the minimum.
  function automatic logic [8:0] bcdInc(input logic [7:0] val, input logic [7:0] last,
                                        input logic [7:0] first);
    if (val >= last)           return {1'b1, first};
    else if (val[3:0] >= 4'd9) return {1'b0, val[7:4] + 4'd1, 4'd0};
    else                       return {1'b0, val[7:4], val[3:0] + 4'd1};
  endfunction

  logic       isLeap;
  logic [7:0] monthEnd;
  logic [8:0] secInc, minInc, hourInc, dowInc, dateInc, monInc, yearInc;
  logic       secC, minC, hourC, monC, yrC;
  logic       wr, rdSec, timeWr, prescTick, advance, alarmMatch;
  logic       unusedBits;

  assign isLeap = (~year_q[4] & (year_q[3:0] == 4'd0 || year_q[3:0] == 4'd4 || year_q[3:0] == 4'd8))
                | ( year_q[4] & (year_q[3:0] == 4'd2 || year_q[3:0] == 4'd6));

  always_comb begin
    case (month_q)
      5'h04, 5'h06, 5'h09, 5'h11: monthEnd = 8'h30;
      5'h02:                      monthEnd = isLeap ? 8'h29 : 8'h28;
      default:                    monthEnd = 8'h31;
    endcase
  end

  assign secInc  = bcdInc({1'b0, sec_q},   8'h59, 8'h00);
  assign minInc  = bcdInc({1'b0, min_q},   8'h59, 8'h00);
  assign hourInc = bcdInc({2'b0, hour_q},  8'h23, 8'h00);
  assign dowInc  = bcdInc({5'b0, dow_q},   8'h07, 8'h01);
  assign dateInc = bcdInc({2'b0, date_q},  monthEnd, 8'h01);
  assign monInc  = bcdInc({3'b0, month_q}, 8'h12, 8'h01);
  assign yearInc = bcdInc(year_q,          8'h99, 8'h00);

  assign secC  = secInc[8];
  assign minC  = secC  & minInc[8];
  assign hourC = minC  & hourInc[8];
  assign monC  = hourC & dateInc[8];
  assign yrC   = monC  & monInc[8];

  assign unusedBits = ^{secInc[7], minInc[7], hourInc[7:6], dowInc[7:3], dateInc[7:6],
                        monInc[7:5], yrC & yearInc[8]};

  assign wr        = cs_i & we_i;
  assign rdSec     = cs_i & ~we_i & (address_i == 4'h0);
  assign timeWr    = wr & (address_i <= 4'h6);
  assign prescTick = (presc_q == PRESC_LAST);
  assign advance   = ~halt_q & (prescTick | pend_q);

  assign alarmMatch = (almSec_q[7]  | (almSec_q[6:0]  == sec_q))
                    & (almMin_q[7]  | (almMin_q[6:0]  == min_q))
                    & (almHour_q[7] | (almHour_q[5:0] == hour_q));

  // A SEC write restarts the second; any other time write defers a coincident tick by one cycle.
  always_comb begin
    presc_d     = presc_q;
    pend_d      = pend_q;
    alarmEval_d = 1'b0;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    dow_d       = dow_q;
    date_d      = date_q;
    month_d     = month_q;
    year_d      = year_q;
    almSec_d    = almSec_q;
    almMin_d    = almMin_q;
    almHour_d   = almHour_q;
    halt_d      = halt_q;
    ie_d        = ie_q;
    flag_d      = flag_q;
    shadow_d    = shadow_q;

    if (wr && address_i == 4'h0) presc_d = '0;
    else if (!halt_q)            presc_d = prescTick ? '0 : presc_q + PW'(1);

    if (wr && address_i == 4'h0) begin
      pend_d = 1'b0;
    end else if (advance && timeWr) begin
      pend_d = 1'b1;
    end else if (advance) begin
      pend_d      = 1'b0;
      alarmEval_d = 1'b1;
      sec_d       = secInc[6:0];
      if (secC)  min_d   = minInc[6:0];
      if (minC)  hour_d  = hourInc[5:0];
      if (hourC) begin
        dow_d  = dowInc[2:0];
        date_d = dateInc[5:0];
      end
      if (monC)  month_d = monInc[4:0];
      if (yrC)   year_d  = yearInc[7:0];
    end

    if (wr) begin
      case (address_i)
        4'h0: sec_d     = db_i[6:0];
        4'h1: min_d     = db_i[6:0];
        4'h2: hour_d    = db_i[5:0];
        4'h3: dow_d     = db_i[2:0];
        4'h4: date_d    = db_i[5:0];
        4'h5: month_d   = db_i[4:0];
        4'h6: year_d    = db_i;
        4'h8: almSec_d  = db_i;
        4'h9: almMin_d  = db_i;
        4'hA: almHour_d = db_i;
        4'hB: begin
          halt_d = db_i[0];
          ie_d   = db_i[1];
        end
        4'hC: if (db_i[0]) flag_d = 1'b0;
        default: ;
      endcase
    end

    if (alarmEval_q && alarmMatch) flag_d = 1'b1;

    if (rdSec) shadow_d = {min_q, hour_q, dow_q, date_q, month_q, year_q};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q     <= '0;
      pend_q      <= 1'b0;
      alarmEval_q <= 1'b0;
      sec_q       <= 7'h00;
      min_q       <= 7'h00;
      hour_q      <= 6'h00;
      dow_q       <= 3'd1;
      date_q      <= 6'h01;
      month_q     <= 5'h01;
      year_q      <= 8'h00;
      almSec_q    <= 8'h00;
      almMin_q    <= 8'h00;
      almHour_q   <= 8'h00;
      halt_q      <= 1'b0;
      ie_q        <= 1'b0;
      flag_q      <= 1'b0;
      shadow_q    <= '0;
    end else begin
      presc_q     <= presc_d;
      pend_q      <= pend_d;
      alarmEval_q <= alarmEval_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      dow_q       <= dow_d;
      date_q      <= date_d;
      month_q     <= month_d;
      year_q      <= year_d;
      almSec_q    <= almSec_d;
      almMin_q    <= almMin_d;
      almHour_q   <= almHour_d;
      halt_q      <= halt_d;
      ie_q        <= ie_d;
      flag_q      <= flag_d;
      shadow_q    <= shadow_d;
    end
  end

  // Time/date addresses other than SEC return the snapshot taken by the last SEC read.
  always_comb begin
    db_o = 8'h00;
    if (cs_i && !we_i) begin
      case (address_i)
        4'h0: db_o = {1'b0, sec_q};
        4'h1: db_o = {1'b0, shadow_q[34:28]};
        4'h2: db_o = {2'b0, shadow_q[27:22]};
        4'h3: db_o = {5'b0, shadow_q[21:19]};
        4'h4: db_o = {2'b0, shadow_q[18:13]};
        4'h5: db_o = {3'b0, shadow_q[12:8]};
        4'h6: db_o = shadow_q[7:0];
        4'h7: db_o = CENTURY;
        4'h8: db_o = almSec_q;
        4'h9: db_o = almMin_q;
        4'hA: db_o = almHour_q;
        4'hB: db_o = {6'b0, ie_q, halt_q};
        4'hC: db_o = {7'b0, flag_q};
        default: db_o = 8'h00;
      endcase
    end
  end

  assign tick_1hz_o  = (presc_q < PRESC_HALF);
  assign alarm_irq_o = flag_q & ie_q;
  assign hours_o     = hour_q;
  assign min_o       = min_q;
  assign sec_o       = sec_q;

endmodule
